// File: rtl/player_action_scheduler_pkg.sv
// Shared definitions for the player action scheduler.
//   - Direction encoding used by move_dir, attack_dir and facing.
//   - Scheduler FSM state enum.
//   - Full-health value loaded at reset.
//   - decode_dir(): turns the four direction buttons into a direction code
//     plus a valid flag (valid only when exactly one button is pressed).
package player_action_scheduler_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    localparam logic [1:0] HEALTH_MAX = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MOVE_WAIT = 3'd1,
        ST_ATTACK    = 3'd2,
        ST_COOLDOWN  = 3'd3,
        ST_DEAD      = 3'd4
    } state_t;

    // Returns {valid, dir}. Chords and no-press both decode as invalid.
    function automatic logic [2:0] decode_dir(input logic up, input logic right,
                                              input logic down, input logic left);
        logic [2:0] res;
        res = {1'b0, DIR_UP};
        case ({up, right, down, left})
            4'b1000: res = {1'b1, DIR_UP};
            4'b0100: res = {1'b1, DIR_RIGHT};
            4'b0010: res = {1'b1, DIR_DOWN};
            4'b0001: res = {1'b1, DIR_LEFT};
            default: res = {1'b0, DIR_UP};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/player_action_scheduler_frame_counter.sv
// frame_counter: frame_tick-gated down-counter used for every frame timer.
//   clk, reset  : clock, asynchronous active-low reset (count -> 0)
//   tick        : frame_tick; the count only moves on these cycles
//   load        : load load_val (wins over a simultaneous tick)
//   load_val    : value to load
//   done        : high on a tick cycle that ends the window (count <= 1),
//                 so a load of N ends on the N-th following tick and a load
//                 of 0 ends on the very next tick
// The count saturates at zero; it never wraps.
module frame_counter
    import player_action_scheduler_pkg::*;
#(
    parameter int MAX = 1,
    localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = tick && (count <= W'(1));

endmodule

// File: rtl/player_action_scheduler.sv
// player_action_scheduler: frame-rate controller between the controller
// input decoder and the player datapath.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   frame_tick          one-cycle pulse per video frame; all decisions happen here
//   A, B                attack buttons
//   up/down/left/right  direction buttons (one-hot press = valid direction)
//   player_hit          one-cycle hit pulse from collision logic
//   move_cmd/move_dir   single-cycle move-one-tile command and its direction
//   attack_active       sword armed; attack_dir its (frozen) orientation
//   facing              last accepted direction
//   player_health       hearts, 3..0
//   invincible          hits ignored while high
//   game_over           sticky until reset
//   fsm_state           debug view of the scheduler state (state_t encoding)
//
// Build option: define INPUT_SYNC_EN to pass the buttons and player_hit
// through two-flop synchronisers (2 cycles extra input latency; player_hit
// is then edge-detected so a longer pulse counts once).
//
// Handshake: there is no backpressure. move_cmd is a fire-and-forget pulse,
// valid for exactly one cycle, with move_dir valid alongside it.
module player_action_scheduler
    import player_action_scheduler_pkg::*;
#(
    parameter int MOVE_PERIOD     = 4,
    parameter int ATTACK_FRAMES   = 8,
    parameter int COOLDOWN_FRAMES = 16,
    parameter int IFRAME_COUNT    = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       A,
    input  logic       B,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       player_hit,
    output logic       move_cmd,
    output logic [1:0] move_dir,
    output logic       attack_active,
    output logic [1:0] attack_dir,
    output logic [1:0] facing,
    output logic [1:0] player_health,
    output logic       invincible,
    output logic       game_over,
    output logic [2:0] fsm_state
);

    localparam int ACT_MAX = (ATTACK_FRAMES > COOLDOWN_FRAMES) ? ATTACK_FRAMES : COOLDOWN_FRAMES;
    localparam int MV_W    = (MOVE_PERIOD < 1) ? 1 : $clog2(MOVE_PERIOD + 1);
    localparam int ACT_W   = (ACT_MAX < 1) ? 1 : $clog2(ACT_MAX + 1);
    localparam int IF_W    = (IFRAME_COUNT < 1) ? 1 : $clog2(IFRAME_COUNT + 1);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic a_s, b_s, up_s, down_s, left_s, right_s, hit_ev;

`ifdef INPUT_SYNC_EN
    logic [6:0] sync1, sync2;
    logic       hit_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            hit_d <= 1'b0;
        end else begin
            sync1 <= {A, B, up, down, left, right, player_hit};
            sync2 <= sync1;
            hit_d <= sync2[0];
        end
    end

    assign {a_s, b_s, up_s, down_s, left_s, right_s} = sync2[6:1];
    assign hit_ev = sync2[0] & ~hit_d;
`else
    assign a_s     = A;
    assign b_s     = B;
    assign up_s    = up;
    assign down_s  = down;
    assign left_s  = left;
    assign right_s = right;
    assign hit_ev  = player_hit;
`endif

    logic [2:0] dir_dec;
    logic       dir_valid;
    logic [1:0] dir;

    assign dir_dec   = decode_dir(up_s, right_s, down_s, left_s);
    assign dir_valid = dir_dec[2];
    assign dir       = dir_dec[1:0];

    // ------------------------------------------------------------------
    // Frame timers
    // ------------------------------------------------------------------
    logic             mv_load, mv_done;
    logic             act_load, act_done;
    logic [ACT_W-1:0] act_load_val;
    logic             if_load, if_done;

    frame_counter #(.MAX(MOVE_PERIOD)) u_move_cnt (
        .clk      (clk),
        .reset    (reset),
        .tick     (frame_tick),
        .load     (mv_load),
        .load_val (MV_W'(MOVE_PERIOD - 1)),
        .done     (mv_done)
    );

    frame_counter #(.MAX(ACT_MAX)) u_action_cnt (
        .clk      (clk),
        .reset    (reset),
        .tick     (frame_tick),
        .load     (act_load),
        .load_val (act_load_val),
        .done     (act_done)
    );

    frame_counter #(.MAX(IFRAME_COUNT)) u_iframe_cnt (
        .clk      (clk),
        .reset    (reset),
        .tick     (frame_tick),
        .load     (if_load),
        .load_val (IF_W'(IFRAME_COUNT)),
        .done     (if_done)
    );

    // ------------------------------------------------------------------
    // Health / invincibility, independent of the scheduler state
    // ------------------------------------------------------------------
    logic hit_accept;

    assign hit_accept = hit_ev && !invincible && (player_health != 2'b00);
    assign if_load    = hit_accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            player_health <= HEALTH_MAX;
            invincible    <= 1'b0;
        end else if (player_health == 2'b00) begin
            invincible <= 1'b0;
        end else if (hit_accept) begin
            player_health <= player_health - 2'b01;
            invincible    <= 1'b1;
        end else if (invincible && if_done) begin
            invincible <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Scheduler FSM
    // ------------------------------------------------------------------
    state_t     state, state_n;
    logic       move_cmd_n, attack_active_n, game_over_n;
    logic [1:0] move_dir_n, attack_dir_n, facing_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            move_cmd      <= 1'b0;
            move_dir      <= DIR_UP;
            attack_active <= 1'b0;
            attack_dir    <= DIR_RIGHT;
            facing        <= DIR_RIGHT;
            game_over     <= 1'b0;
        end else begin
            state         <= state_n;
            move_cmd      <= move_cmd_n;
            move_dir      <= move_dir_n;
            attack_active <= attack_active_n;
            attack_dir    <= attack_dir_n;
            facing        <= facing_n;
            game_over     <= game_over_n;
        end
    end

    always_comb begin
        state_n         = state;
        move_cmd_n      = 1'b0;
        move_dir_n      = move_dir;
        attack_active_n = attack_active;
        attack_dir_n    = attack_dir;
        facing_n        = facing;
        game_over_n     = game_over;
        mv_load         = 1'b0;
        act_load        = 1'b0;
        act_load_val    = '0;

        // Zero health overrides whatever the FSM is doing, mid-attack included.
        if (player_health == 2'b00) begin
            state_n         = ST_DEAD;
            attack_active_n = 1'b0;
            game_over_n     = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_tick) begin
                        if (a_s || b_s) begin
                            state_n         = ST_ATTACK;
                            attack_active_n = 1'b1;
                            attack_dir_n    = dir_valid ? dir : facing;
                            if (dir_valid) begin
                                facing_n = dir;
                            end
                            act_load     = 1'b1;
                            act_load_val = ACT_W'(ATTACK_FRAMES);
                        end else if (dir_valid) begin
                            state_n    = ST_MOVE_WAIT;
                            move_cmd_n = 1'b1;
                            move_dir_n = dir;
                            facing_n   = dir;
                            mv_load    = 1'b1;
                        end
                    end
                end
                ST_MOVE_WAIT: begin
                    if (mv_done) begin
                        state_n = ST_IDLE;
                    end
                end
                ST_ATTACK: begin
                    if (act_done) begin
                        state_n         = ST_COOLDOWN;
                        attack_active_n = 1'b0;
                        act_load        = 1'b1;
                        act_load_val    = ACT_W'(COOLDOWN_FRAMES);
                    end
                end
                ST_COOLDOWN: begin
                    if (act_done) begin
                        state_n = ST_IDLE;
                    end
                end
                ST_DEAD: begin
                    attack_active_n = 1'b0;
                    game_over_n     = 1'b1;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_player_action_scheduler.sv
// Directed bench for player_action_scheduler (default parameters, default build).
module tb_player_action_scheduler;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic       A, B, up, down, left, right;
    logic       player_hit;
    logic       move_cmd;
    logic [1:0] move_dir;
    logic       attack_active;
    logic [1:0] attack_dir;
    logic [1:0] facing;
    logic [1:0] player_health;
    logic       invincible;
    logic       game_over;
    logic [2:0] fsm_state;

    int n_tests;
    int n_fail;
    int n_moves;
    int n_att;
    int n_inv;

    player_action_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .A             (A),
        .B             (B),
        .up            (up),
        .down          (down),
        .left          (left),
        .right         (right),
        .player_hit    (player_hit),
        .move_cmd      (move_cmd),
        .move_dir      (move_dir),
        .attack_active (attack_active),
        .attack_dir    (attack_dir),
        .facing        (facing),
        .player_health (player_health),
        .invincible    (invincible),
        .game_over     (game_over),
        .fsm_state     (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // One frame: tick for one cycle, then two quiet cycles. invincible is
    // sampled on the tick cycle; move_cmd / attack_active right after it.
    task automatic run_frame();
        @(negedge clk);
        if (invincible) n_inv++;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        if (move_cmd) n_moves++;
        if (attack_active) n_att++;
        @(negedge clk);
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) run_frame();
    endtask

    task automatic hit_pulse();
        @(negedge clk);
        player_hit = 1'b1;
        @(negedge clk);
        player_hit = 1'b0;
    endtask

    task automatic set_btn(input logic a, input logic u, input logic d,
                           input logic l, input logic r);
        A = a; up = u; down = d; left = l; right = r;
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_move_cmd"},   32'(move_cmd),      32'd0);
        check({pfx, "_move_dir"},   32'(move_dir),      32'd0);
        check({pfx, "_attack"},     32'(attack_active), 32'd0);
        check({pfx, "_attack_dir"}, 32'(attack_dir),    32'd1);
        check({pfx, "_facing"},     32'(facing),        32'd1);
        check({pfx, "_health"},     32'(player_health), 32'd3);
        check({pfx, "_invincible"}, 32'(invincible),    32'd0);
        check({pfx, "_game_over"},  32'(game_over),     32'd0);
        check({pfx, "_state"},      32'(fsm_state),     32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_tests = 0; n_fail = 0; n_moves = 0; n_att = 0; n_inv = 0;
        reset = 1'b0; frame_tick = 1'b0; B = 1'b0; player_hit = 1'b0;
        set_btn(0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b1;

        // Hold right 12 frames: moves on frames 0, 4, 8.
        set_btn(0, 0, 0, 0, 1);
        n_moves = 0;
        run_frames(12);
        check("hold_right_moves", n_moves, 3);
        check("hold_right_dir", 32'(move_dir), 32'd1);
        check("hold_right_facing", 32'(facing), 32'd1);

        // Chord up+left is no direction.
        set_btn(0, 1, 0, 1, 0);
        n_moves = 0;
        run_frames(10);
        check("chord_moves", n_moves, 0);
        check("chord_facing", 32'(facing), 32'd1);

        // Hold left 4 frames: a single move, facing left.
        set_btn(0, 0, 0, 1, 0);
        n_moves = 0;
        run_frames(4);
        check("left_moves", n_moves, 1);
        check("left_dir", 32'(move_dir), 32'd3);
        check("left_facing", 32'(facing), 32'd3);

        // Attack with down on frame 0.
        set_btn(1, 0, 1, 0, 0);
        n_moves = 0; n_att = 0;
        run_frame();
        check("atk_active", 32'(attack_active), 32'd1);
        check("atk_dir", 32'(attack_dir), 32'd2);
        check("atk_facing", 32'(facing), 32'd2);
        check("atk_state", 32'(fsm_state), 32'd2);
        // Frames 1..24: attack then cooldown, inputs ignored.
        for (int k = 1; k <= 24; k++) begin
            set_btn(k[0], 0, 0, 0, 1);
            run_frame();
        end
        check("atk_frames_high", n_att, 8);
        check("atk_cd_moves", n_moves, 0);
        check("atk_cd_active_end", 32'(attack_active), 32'd0);
        check("atk_cd_facing", 32'(facing), 32'd2);
        check("atk_dir_frozen", 32'(attack_dir), 32'd2);
        // Frame 25: first move after cooldown.
        set_btn(0, 0, 0, 0, 1);
        run_frame();
        check("first_move_f25", n_moves, 1);
        check("first_move_dir", 32'(move_dir), 32'd1);
        set_btn(0, 0, 0, 0, 0);
        run_frames(3);

        // Hits: second hit within invincibility is dropped.
        hit_pulse();
        check("hit1_health", 32'(player_health), 32'd2);
        check("hit1_inv", 32'(invincible), 32'd1);
        n_inv = 0;
        run_frames(5);
        hit_pulse();
        check("hit2_dropped", 32'(player_health), 32'd2);
        run_frames(26);
        check("inv_31_frames", n_inv, 31);
        check("inv_still_high", 32'(invincible), 32'd1);
        run_frame();
        check("inv_32_frames", n_inv, 32);
        check("inv_cleared", 32'(invincible), 32'd0);
        hit_pulse();
        check("hit3_health", 32'(player_health), 32'd1);
        check("hit3_inv", 32'(invincible), 32'd1);
        run_frames(32);
        check("inv3_cleared", 32'(invincible), 32'd0);

        // Death mid-attack (attack with no direction uses facing = right).
        set_btn(1, 0, 0, 0, 0);
        run_frame();
        set_btn(0, 0, 0, 0, 0);
        check("dead_atk_active", 32'(attack_active), 32'd1);
        check("dead_atk_dir", 32'(attack_dir), 32'd1);
        run_frames(2);
        hit_pulse();
        check("dead_health0", 32'(player_health), 32'd0);
        check("dead_atk_still", 32'(attack_active), 32'd1);
        check("dead_go_not_yet", 32'(game_over), 32'd0);
        @(negedge clk);
        check("dead_atk_dropped", 32'(attack_active), 32'd0);
        check("dead_game_over", 32'(game_over), 32'd1);
        check("dead_inv_cleared", 32'(invincible), 32'd0);
        check("dead_state", 32'(fsm_state), 32'd4);
        set_btn(1, 0, 0, 0, 1);
        n_moves = 0; n_att = 0;
        run_frames(5);
        hit_pulse();
        check("dead_no_moves", n_moves, 0);
        check("dead_no_attack", n_att, 0);
        check("dead_go_sticky", 32'(game_over), 32'd1);
        check("dead_health_stays", 32'(player_health), 32'd0);
        set_btn(0, 0, 0, 0, 0);

        // Reset releases DEAD; then reset asynchronously mid-attack at health 1.
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("rerst_health", 32'(player_health), 32'd3);
        check("rerst_game_over", 32'(game_over), 32'd0);
        hit_pulse();
        run_frames(33);
        hit_pulse();
        check("pre_async_health", 32'(player_health), 32'd1);
        run_frames(33);
        set_btn(1, 0, 1, 0, 0);
        run_frame();
        set_btn(0, 0, 0, 0, 0);
        check("pre_async_attack", 32'(attack_active), 32'd1);
        check("pre_async_state", 32'(fsm_state), 32'd2);
        #3;
        reset = 1'b0;
        #1;
        check_reset_values("async");
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
